minterm_checker: RTL

Sequential response checker for 4-input combinational function blocks. On `start` it sweeps the full input space, driving `stim` = 0, 1, … 2^N_IN−1 into the device under check and sampling its 1-bit response `resp` for each vector. It assembles the captured truth table, compares it against a parameterised minterm mask, and reports pass/fail plus the lowest failing index. It is the capture and compare end of the exhaustive-stimulus flow used by the team's function blocks, and runs in-system or in benches without `$finish`-driven timing.

---
 rtl/minterm_pkg.sv | 5 +
 rtl/minterm_checker_if.sv | 8 +
 rtl/settle_counter.sv | 15 +
 rtl/minterm_checker.sv | 60 ++++++
 4 files changed

// File: rtl/minterm_pkg.sv
// minterm_pkg: shared state type and default truth table for the minterm checker
package minterm_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mc_state_t;
    localparam logic [15:0] MC_FN_DEFAULT = 16'hEF77;
endpackage

// File: rtl/minterm_checker_if.sv
// minterm_checker_if: control, stimulus and result bundle between a sweep driver and the checker
interface minterm_checker_if #(parameter int N_IN = 4);
    logic start, abort, resp, busy, done, pass, fail_valid;
    logic [N_IN-1:0] stim, first_fail;
    logic [2**N_IN-1:0] captured;
    modport master(output start, abort, resp, input stim, busy, done, pass, captured, fail_valid, first_fail);
    modport slave(input start, abort, resp, output stim, busy, done, pass, captured, fail_valid, first_fail);
endinterface

// File: rtl/settle_counter.sv
// settle_counter: per-vector hold counter; last marks the edge on which the response is sampled
module settle_counter #(parameter logic [3:0] SETTLE = 4'd0) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic last
);
    logic [3:0] cnt;
    always_ff @(posedge clk)
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= SETTLE;
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    assign last = cnt == '0;
endmodule

// File: rtl/minterm_checker.sv
// minterm_checker: exhaustive input sweep, truth-table capture and compare against EXPECTED
module minterm_checker import minterm_pkg::*; #(
    parameter int N_IN = 4,
    parameter logic [2**N_IN-1:0] EXPECTED = MC_FN_DEFAULT,
    parameter int SETTLE = 0
) (
    input logic clk,
    input logic rst_n,
    minterm_checker_if.slave bus
);
    localparam int W = 2**N_IN;
    mc_state_t state;
    logic last, hit, last_vec;
    logic [W-1:0] cap_next;
    assign hit = state == RUN && !bus.abort && last;
    assign last_vec = &bus.stim;
    // pass must include the bit sampled on the final edge, so compare the next-state table
    assign cap_next = bus.captured | (W'(bus.resp) << bus.stim);
    assign bus.busy = state == RUN;
    assign bus.done = state == DONE;
    settle_counter #(.SETTLE(4'(SETTLE))) u_settle (
        .clk(clk),
        .rst_n(rst_n),
        .load((state == IDLE && bus.start) || (hit && !last_vec)),
        .en(state == RUN),
        .last(last)
    );
    always_ff @(posedge clk)
        if (!rst_n) begin
            state <= IDLE;
            bus.stim <= '0;
            bus.pass <= 1'b0;
            bus.captured <= '0;
            bus.fail_valid <= 1'b0;
            bus.first_fail <= '0;
        end else if (state == IDLE && bus.start) begin
            state <= RUN;
            bus.stim <= '0;
            bus.pass <= 1'b0;
            bus.captured <= '0;
            bus.fail_valid <= 1'b0;
            bus.first_fail <= '0;
        end else if (state == RUN && bus.abort) begin
            state <= IDLE;
        end else if (hit) begin
            bus.captured <= cap_next;
            if (bus.resp != EXPECTED[bus.stim] && !bus.fail_valid) begin
                bus.first_fail <= bus.stim;
                bus.fail_valid <= 1'b1;
            end
            if (last_vec) begin
                state <= DONE;
                bus.pass <= cap_next == EXPECTED;
            end else begin
                bus.stim <= bus.stim + 1'b1;
            end
        end else if (state == DONE) begin
            state <= IDLE;
        end
endmodule
